// File: rtl/median_ctrl_pkg.sv
// Shared types and constants for the 3x3 median filter scheduler.
// Window offsets are used by median_tap_gen (see MEDIAN_CTRL_CLAMP_PAD_EN there).
package median_ctrl_pkg;

    localparam int unsigned TAP_NUM     = 9;
    localparam int unsigned CYC_PER_PIX = 11;
    localparam int unsigned TAP_W       = 4;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDrain,
        StResult,
        StDone
    } state_e;

    // Row-major 3x3 window: dx = tap%3 - 1.
    function automatic logic signed [1:0] tap_dx(input logic [TAP_W-1:0] tap);
        logic signed [1:0] r_dx;
        case (tap)
            4'd0, 4'd3, 4'd6: r_dx = -2'sd1;
            4'd1, 4'd4, 4'd7: r_dx = 2'sd0;
            default:          r_dx = 2'sd1;
        endcase
        return r_dx;
    endfunction

    // Row-major 3x3 window: dy = tap/3 - 1.
    function automatic logic signed [1:0] tap_dy(input logic [TAP_W-1:0] tap);
        logic signed [1:0] r_dy;
        case (tap)
            4'd0, 4'd1, 4'd2: r_dy = -2'sd1;
            4'd3, 4'd4, 4'd5: r_dy = 2'sd0;
            default:          r_dy = 2'sd1;
        endcase
        return r_dy;
    endfunction

endpackage

// File: rtl/median_tap_gen.sv
// Combinational (x, y, tap) -> SRAM address and read qualifier for one window tap.
// MEDIAN_CTRL_CLAMP_PAD_EN selects border replicate; otherwise out-of-image taps are zero pads.
module median_tap_gen
    import median_ctrl_pkg::*;
#(
    parameter int unsigned IMG_W  = 8,
    parameter int unsigned IMG_H  = 8,
    parameter int unsigned ADDR_W = 6
) (
    input  logic [ADDR_W-1:0] i_x,
    input  logic [ADDR_W-1:0] i_y,
    input  logic [TAP_W-1:0]  i_tap,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_in_bounds
);

    localparam int unsigned CW = ADDR_W + 1;
    localparam logic signed [CW-1:0] X_MAX = CW'(IMG_W - 1);
    localparam logic signed [CW-1:0] Y_MAX = CW'(IMG_H - 1);

    logic signed [1:0]    w_dx;
    logic signed [1:0]    w_dy;
    logic signed [CW-1:0] w_cx;
    logic signed [CW-1:0] w_cy;
    logic signed [CW-1:0] w_sx;
    logic signed [CW-1:0] w_sy;

    assign w_dx = tap_dx(i_tap);
    assign w_dy = tap_dy(i_tap);
    assign w_cx = $signed({1'b0, i_x}) + $signed({{(CW-2){w_dx[1]}}, w_dx});
    assign w_cy = $signed({1'b0, i_y}) + $signed({{(CW-2){w_dy[1]}}, w_dy});

`ifdef MEDIAN_CTRL_CLAMP_PAD_EN
    // Clamped taps are real reads of the nearest border pixel.
    always_comb begin
        w_sx = w_cx;
        w_sy = w_cy;
        if (w_cx[CW-1]) begin
            w_sx = '0;
        end else if (w_cx > X_MAX) begin
            w_sx = X_MAX;
        end
        if (w_cy[CW-1]) begin
            w_sy = '0;
        end else if (w_cy > Y_MAX) begin
            w_sy = Y_MAX;
        end
        o_in_bounds = 1'b1;
    end
`else
    logic w_x_in;
    logic w_y_in;

    assign w_x_in = !w_cx[CW-1] && (w_cx <= X_MAX);
    assign w_y_in = !w_cy[CW-1] && (w_cy <= Y_MAX);

    always_comb begin
        w_sx        = w_cx;
        w_sy        = w_cy;
        o_in_bounds = w_x_in && w_y_in;
    end
`endif

    // Only meaningful when o_in_bounds; the top gates it off otherwise.
    assign o_addr = w_sy[ADDR_W-1:0] * ADDR_W'(IMG_W) + w_sx[ADDR_W-1:0];

endmodule

// File: rtl/median_filter_ctrl.sv
// 3x3 median filter scheduler: raster-scans the image, feeds 9 taps per pixel, captures results.
// Pad mode selected by MEDIAN_CTRL_CLAMP_PAD_EN (replicate) or default zero padding.
module median_filter_ctrl
    import median_ctrl_pkg::*;
#(
    parameter int unsigned IMG_W  = 8,
    parameter int unsigned IMG_H  = 8,
    parameter int unsigned DATA_W = 8,
    localparam int unsigned ADDR_W = $clog2(IMG_W * IMG_H)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_sram_ren,
    output logic [ADDR_W-1:0] o_sram_addr,
    input  logic [DATA_W-1:0] i_sram_rdata,
    output logic              o_med_clear,
    output logic              o_med_active,
    output logic [DATA_W-1:0] o_med_data,
    input  logic [DATA_W-1:0] i_med_result,
    output logic              o_out_valid,
    output logic [DATA_W-1:0] o_out_data,
    output logic [ADDR_W-1:0] o_out_addr
);

    localparam logic [ADDR_W-1:0] X_LAST   = ADDR_W'(IMG_W - 1);
    localparam logic [ADDR_W-1:0] Y_LAST   = ADDR_W'(IMG_H - 1);
    localparam logic [TAP_W-1:0]  TAP_LAST = TAP_W'(TAP_NUM - 1);

    state_e            r_state;
    state_e            w_state_nxt;
    logic [ADDR_W-1:0] r_x;
    logic [ADDR_W-1:0] r_y;
    logic [TAP_W-1:0]  r_tap;
    logic              r_med_active;
    logic              r_med_real;

    logic              w_fetch;
    logic              w_tap_in;
    logic              w_ren;
    logic              w_last_pix;
    logic [ADDR_W-1:0] w_tap_addr;
    logic [ADDR_W-1:0] w_pix_addr;

    median_tap_gen #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_W (ADDR_W)
    ) u_tap_gen (
        .i_x         (r_x),
        .i_y         (r_y),
        .i_tap       (r_tap),
        .o_addr      (w_tap_addr),
        .o_in_bounds (w_tap_in)
    );

    assign w_fetch    = (r_state == StFetch);
    assign w_ren      = w_fetch && w_tap_in;
    assign w_last_pix = (r_x == X_LAST) && (r_y == Y_LAST);
    assign w_pix_addr = r_y * ADDR_W'(IMG_W) + r_x;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle:   if (i_start) w_state_nxt = StFetch;
            StFetch:  if (r_tap == TAP_LAST) w_state_nxt = StDrain;
            StDrain:  w_state_nxt = StResult;
            StResult: w_state_nxt = w_last_pix ? StDone : StFetch;
            StDone:   w_state_nxt = StIdle;
            default:  w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tap <= '0;
            r_x   <= '0;
            r_y   <= '0;
        end else begin
            if (w_fetch) begin
                r_tap <= (r_tap == TAP_LAST) ? '0 : r_tap + 1'b1;
            end
            if (r_state == StResult) begin
                if (w_last_pix) begin
                    r_x <= '0;
                    r_y <= '0;
                end else if (r_x == X_LAST) begin
                    r_x <= '0;
                    r_y <= r_y + 1'b1;
                end else begin
                    r_x <= r_x + 1'b1;
                end
            end
        end
    end

    // Insert strobe trails the fetch by one cycle to line up with the SRAM read latency.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_med_active <= 1'b0;
            r_med_real   <= 1'b0;
        end else begin
            r_med_active <= w_fetch;
            r_med_real   <= w_ren;
        end
    end

    always_comb begin
        o_busy      = 1'b0;
        o_done      = 1'b0;
        o_sram_ren  = 1'b0;
        o_sram_addr = '0;
        o_med_clear = 1'b0;
        o_out_valid = 1'b0;
        o_out_data  = '0;
        o_out_addr  = '0;
        unique case (r_state)
            StFetch: begin
                o_busy      = 1'b1;
                o_sram_ren  = w_ren;
                o_sram_addr = w_ren ? w_tap_addr : '0;
                o_med_clear = (r_tap == '0);
            end
            StDrain: begin
                o_busy = 1'b1;
            end
            StResult: begin
                o_busy      = 1'b1;
                o_out_valid = 1'b1;
                o_out_data  = i_med_result;
                o_out_addr  = w_pix_addr;
            end
            StDone: begin
                o_done = 1'b1;
            end
            default: begin
            end
        endcase
        o_med_active = r_med_active;
        o_med_data   = (r_med_active && r_med_real) ? i_sram_rdata : '0;
    end

endmodule

// File: tb/tb_median_filter_ctrl.sv
// Directed bench for median_filter_ctrl on a 4x4 image with an SRAM model and a median-of-9 model.
// Expected pad results follow MEDIAN_CTRL_CLAMP_PAD_EN when defined.
module tb_median_filter_ctrl;

    localparam int unsigned IMG_W  = 4;
    localparam int unsigned IMG_H  = 4;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 4;
    localparam int NPIX = 16;

`ifdef MEDIAN_CTRL_CLAMP_PAD_EN
    localparam int EXP_REN = 144;
    int ramp_exp [0:4] = '{10, 20, 50, 100, 140};
`else
    localparam int EXP_REN = 100;
    int ramp_exp [0:4] = '{0, 10, 50, 100, 0};
`endif
    int ramp_idx [0:4] = '{0, 1, 5, 10, 15};

    logic              clk     = 1'b0;
    logic              i_rst_n = 1'b1;
    logic              i_start = 1'b0;
    logic              o_busy;
    logic              o_done;
    logic              o_sram_ren;
    logic [ADDR_W-1:0] o_sram_addr;
    logic [DATA_W-1:0] sram_rdata = '0;
    logic              o_med_clear;
    logic              o_med_active;
    logic [DATA_W-1:0] o_med_data;
    logic [DATA_W-1:0] med_result;
    logic              o_out_valid;
    logic [DATA_W-1:0] o_out_data;
    logic [ADDR_W-1:0] o_out_addr;

    always #5 clk = ~clk;

    median_filter_ctrl #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .DATA_W (DATA_W)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (i_rst_n),
        .i_start      (i_start),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_sram_ren   (o_sram_ren),
        .o_sram_addr  (o_sram_addr),
        .i_sram_rdata (sram_rdata),
        .o_med_clear  (o_med_clear),
        .o_med_active (o_med_active),
        .o_med_data   (o_med_data),
        .i_med_result (med_result),
        .o_out_valid  (o_out_valid),
        .o_out_data   (o_out_data),
        .o_out_addr   (o_out_addr)
    );

    // SRAM model, 1-cycle read latency
    logic [7:0] mem [0:15];
    always @(posedge clk) if (o_sram_ren) sram_rdata <= mem[o_sram_addr];

    // Median-of-9 unit model: collects inserted samples, result is rank 4 of the sorted set
    logic [7:0] samp [0:8] = '{default: 8'd0};
    int med_cnt = 0;
    always @(posedge clk) begin
        if (o_med_clear) begin
            med_cnt <= 0;
        end else if (o_med_active) begin
            if (med_cnt < 9) samp[med_cnt] <= o_med_data;
            med_cnt <= med_cnt + 1;
        end
    end

    function automatic logic [7:0] median9(input logic [7:0] s [0:8]);
        logic [7:0] a [0:8];
        logic [7:0] t;
        a = s;
        for (int i = 1; i < 9; i++)
            for (int j = i; j > 0; j--)
                if (a[j-1] > a[j]) begin
                    t = a[j]; a[j] = a[j-1]; a[j-1] = t;
                end
        return a[4];
    endfunction

    always_comb med_result = median9(samp);

    logic [29:0] all_out;
    assign all_out = {o_busy, o_done, o_sram_ren, o_sram_addr, o_med_clear, o_med_active,
                      o_med_data, o_out_valid, o_out_data, o_out_addr};

    // Per-frame monitor; stats cleared when frame_id changes
    int n_pos = 0;
    int start_pos = 0;
    int frame_id = 0;
    int mon_id = 0;
    int valid_cyc [0:63];
    int valid_addr [0:63];
    int valid_data [0:63];
    int done_cyc [0:3];
    int n_valid, n_done, n_busy, busy_first, busy_last, n_active, bad_active;
    int n_clear, bad_clear, n_ren, n_nonzero;

    always @(posedge clk) n_pos++;

    always @(negedge clk) begin
        int c;
        if (frame_id != mon_id) begin
            mon_id = frame_id;
            n_valid = 0; n_done = 0; n_busy = 0; busy_first = -1; busy_last = -1;
            n_active = 0; bad_active = 0; n_clear = 0; bad_clear = 0; n_ren = 0; n_nonzero = 0;
        end
        c = n_pos - start_pos;
        if (o_busy) begin
            if (busy_first < 0) busy_first = c;
            busy_last = c;
            n_busy++;
        end
        if (o_out_valid) begin
            if (n_valid < 64) begin
                valid_cyc[n_valid]  = c;
                valid_addr[n_valid] = int'(o_out_addr);
                valid_data[n_valid] = int'(o_out_data);
            end
            if (o_out_data != 0) n_nonzero++;
            n_valid++;
        end
        if (o_done) begin
            if (n_done < 4) done_cyc[n_done] = c;
            n_done++;
        end
        if (o_med_active) begin
            n_active++;
            if ((c % 11) < 2) bad_active++;
        end
        if (o_med_clear) begin
            n_clear++;
            if ((c % 11) != 1) bad_clear++;
        end
        if (o_sram_ren) n_ren++;
    end

    int n_checks = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int exp_flat(input int a);
`ifdef MEDIAN_CTRL_CLAMP_PAD_EN
        return (a >= 0) ? 100 : 0;
`else
        return (a == 0 || a == 3 || a == 12 || a == 15) ? 0 : 100;
`endif
    endfunction

    // kind 0: flat 100, 1: ramp 10*a, 2: impulse 255 at addr 5
    task automatic load_mem(input int kind);
        for (int a = 0; a < NPIX; a++) begin
            case (kind)
                0:       mem[a] = 8'd100;
                1:       mem[a] = 8'(10 * a);
                default: mem[a] = (a == 5) ? 8'd255 : 8'd0;
            endcase
        end
    endtask

    task automatic start_frame(input bit hold);
        @(posedge clk); #1;
        frame_id++;
        start_pos = n_pos;
        i_start = 1'b1;
        @(posedge clk); #1;
        if (!hold) i_start = 1'b0;
    endtask

    task automatic wait_cycle(input int n);
        while (n_pos - start_pos < n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_done(input int want, input int budget, input string tag);
        for (int k = 0; k < budget; k++) begin
            if (n_done >= want) break;
            @(posedge clk); #1;
        end
        check_eq(tag, n_done, want);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        load_mem(0);
        #2 i_rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_outputs", 32'(all_out), 32'd0);
        i_rst_n = 1'b1;

        // Flat frame: timing, strobe counts and pad behaviour
        start_frame(1'b0);
        wait_done(1, 400, "flat_done");
        for (int n = 0; n < NPIX; n++) begin
            check_eq($sformatf("flat_cyc%0d", n), valid_cyc[n], 11 + 11 * n);
            check_eq($sformatf("flat_addr%0d", n), valid_addr[n], n);
            check_eq($sformatf("flat_data%0d", n), valid_data[n], exp_flat(n));
        end
        check_eq("flat_done_cyc", done_cyc[0], 177);
        check_eq("flat_busy_first", busy_first, 1);
        check_eq("flat_busy_last", busy_last, 176);
        check_eq("flat_busy_cnt", n_busy, 176);
        check_eq("flat_active_cnt", n_active, 144);
        check_eq("flat_active_slot", bad_active, 0);
        check_eq("flat_clear_cnt", n_clear, 16);
        check_eq("flat_clear_slot", bad_clear, 0);
        check_eq("flat_ren_cnt", n_ren, EXP_REN);
        check_eq("flat_valid_cnt", n_valid, 16);

        // Ramp frame with a start pulse while busy
        load_mem(1);
        start_frame(1'b0);
        wait_cycle(30);
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        wait_done(1, 400, "ramp_done");
        repeat (20) @(posedge clk);
        #1;
        check_eq("ramp_valid_cnt", n_valid, 16);
        check_eq("ramp_done_cnt", n_done, 1);
        check_eq("ramp_done_cyc", done_cyc[0], 177);
        for (int i = 0; i < 5; i++) begin
            check_eq($sformatf("ramp_addr%0d", ramp_idx[i]), valid_addr[ramp_idx[i]], ramp_idx[i]);
            check_eq($sformatf("ramp_data%0d", ramp_idx[i]), valid_data[ramp_idx[i]], ramp_exp[i]);
        end

        // Impulse is rejected everywhere
        load_mem(2);
        start_frame(1'b0);
        wait_done(1, 400, "imp_done");
        check_eq("imp_valid_cnt", n_valid, 16);
        check_eq("imp_nonzero", n_nonzero, 0);

        // Reset mid-frame aborts without o_done
        load_mem(1);
        start_frame(1'b0);
        wait_cycle(50);
        check_eq("rst_busy_before", 32'(o_busy), 32'd1);
        i_rst_n = 1'b0;
        #1;
        check_eq("rst_outputs", 32'(all_out), 32'd0);
        repeat (5) @(posedge clk);
        #1 i_rst_n = 1'b1;
        repeat (200) @(posedge clk);
        #1;
        check_eq("rst_no_done", n_done, 0);
        check_eq("rst_idle", 32'(o_busy), 32'd0);

        start_frame(1'b0);
        wait_done(1, 400, "restart_done");
        check_eq("restart_valid_cnt", n_valid, 16);
        check_eq("restart_data0", valid_data[0], ramp_exp[0]);
        check_eq("restart_data5", valid_data[5], 50);
        check_eq("restart_data10", valid_data[10], 100);
        check_eq("restart_done_cyc", done_cyc[0], 177);

        // Held start: second frame sampled in the IDLE cycle right after o_done
        load_mem(0);
        start_frame(1'b1);
        wait_done(2, 800, "held_done");
        i_start = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        check_eq("held_done2_cyc", done_cyc[1], 355);
        check_eq("held_valid_cnt", n_valid, 32);
        check_eq("held_second_cyc", valid_cyc[16], 189);
        check_eq("held_second_addr", valid_addr[16], 0);
        check_eq("held_second_data", valid_data[16], exp_flat(0));
        check_eq("held_busy_cnt", n_busy, 352);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
